// File: rtl/temp_bcd_formatter.sv
// Signed 13-bit ADT7420 temperature to packed sign/BCD display word.
// Iterative double-dabble: integer part then fraction, fixed 25-cycle latency.
module temp_bcd_formatter #(
  parameter logic [3:0] SIGN_POS = 4'h0,
  parameter logic [3:0] SIGN_NEG = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [12:0] temp_raw,
  output logic        busy,
  output logic        valid,
  output logic [31:0] data,
  output logic        disp_en
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CONV_INT,
    CONV_FRAC,
    DONE
  } state_t;

  state_t      state_q;
  logic [12:0] temp_q;
  logic        sign_q;
  logic [8:0]  int_bin_q;
  logic [13:0] frac_bin_q;
  logic [11:0] int_bcd_q;
  logic [15:0] frac_bcd_q;
  logic [3:0]  cnt_q;

  logic [12:0] mag_d;
  logic [13:0] frac_bin_d;
  logic [11:0] int_adj;
  logic [15:0] frac_adj;
  logic [11:0] int_bcd_d;
  logic [15:0] frac_bcd_d;

  function automatic logic [3:0] dd_digit(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  always_comb begin
    // 13'h1000 negates to itself, which read as unsigned is the correct 4096
    mag_d      = sign_q ? (~temp_q + 13'd1) : temp_q;
    frac_bin_d = {10'd0, mag_d[3:0]} * 14'd625;
    int_adj    = {dd_digit(int_bcd_q[11:8]), dd_digit(int_bcd_q[7:4]),
                  dd_digit(int_bcd_q[3:0])};
    frac_adj   = {dd_digit(frac_bcd_q[15:12]), dd_digit(frac_bcd_q[11:8]),
                  dd_digit(frac_bcd_q[7:4]), dd_digit(frac_bcd_q[3:0])};
    int_bcd_d  = 12'({int_adj, int_bin_q[8]});
    frac_bcd_d = 16'({frac_adj, frac_bin_q[13]});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      temp_q     <= '0;
      sign_q     <= 1'b0;
      int_bin_q  <= '0;
      frac_bin_q <= '0;
      int_bcd_q  <= '0;
      frac_bcd_q <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      data       <= '0;
      disp_en    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            temp_q  <= temp_raw;
            sign_q  <= temp_raw[12];
            busy    <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          int_bin_q  <= mag_d[12:4];
          frac_bin_q <= frac_bin_d;
          int_bcd_q  <= '0;
          frac_bcd_q <= '0;
          cnt_q      <= 4'd8;
          state_q    <= CONV_INT;
        end
        CONV_INT: begin
          int_bcd_q <= int_bcd_d;
          int_bin_q <= {int_bin_q[7:0], 1'b0};
          if (cnt_q == 4'd0) begin
            cnt_q   <= 4'd13;
            state_q <= CONV_FRAC;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        CONV_FRAC: begin
          frac_bcd_q <= frac_bcd_d;
          frac_bin_q <= {frac_bin_q[12:0], 1'b0};
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          data    <= {sign_q ? SIGN_NEG : SIGN_POS, int_bcd_q, frac_bcd_q};
          valid   <= 1'b1;
          disp_en <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_bcd_formatter.sv
// Directed bench for temp_bcd_formatter: reset, conversions, sign edge cases,
// ignored start, back-to-back start and mid-conversion reset.
module tb_temp_bcd_formatter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [12:0] temp_raw;
  logic        busy;
  logic        valid;
  logic [31:0] data;
  logic        disp_en;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  temp_bcd_formatter #(.SIGN_POS(4'h0), .SIGN_NEG(4'hF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .temp_raw (temp_raw),
    .busy     (busy),
    .valid    (valid),
    .data     (data),
    .disp_en  (disp_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after an edge with the DUT idle; returns 1 after edge k+26.
  task automatic run_conv(input string tag, input logic [12:0] t, input logic [31:0] exp);
    logic ok;
    start    = 1'b1;
    temp_raw = t;
    tick();
    start = 1'b0;
    ok = (busy === 1'b1 && valid === 1'b0);
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (!(busy === 1'b1 && valid === 1'b0)) ok = 1'b0;
    end
    chk({tag, " busy window"}, {31'd0, ok}, 32'd1);
    tick();
    chk({tag, " valid"}, {31'd0, valid}, 32'd1);
    chk({tag, " busy fall"}, {31'd0, busy}, 32'd0);
    chk({tag, " data"}, data, exp);
    chk({tag, " disp_en"}, {31'd0, disp_en}, 32'd1);
    tick();
    chk({tag, " valid one cycle"}, {31'd0, valid}, 32'd0);
    chk({tag, " data held"}, data, exp);
  endtask

  initial begin
    logic ok;
    rst_n    = 1'b0;
    start    = 1'b0;
    temp_raw = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state and quiet idle
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("idle quiet", {31'd0, ok}, 32'd1);
    chk("reset data", data, 32'h0000_0000);
    chk("reset disp_en", {31'd0, disp_en}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);

    run_conv("p25.0", 13'h0190, 32'h0025_0000);
    run_conv("p25.5625", 13'h0199, 32'h0025_5625);
    run_conv("m0.0625", 13'h1FFF, 32'hF000_0625);
    run_conv("m256", 13'h1000, 32'hF256_0000);
    run_conv("p255.9375", 13'h0FFF, 32'h0255_9375);

    // start while busy is ignored; temp_raw changes have no effect
    start    = 1'b1;
    temp_raw = 13'h0190;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    start    = 1'b1;
    temp_raw = 13'h1FFF;
    tick();
    start = 1'b0;
    for (int i = 6; i <= 24; i++) tick();
    chk("ignore busy", {31'd0, busy}, 32'd1);
    tick();
    chk("ignore valid", {31'd0, valid}, 32'd1);
    chk("ignore data", data, 32'h0025_0000);

    // back-to-back: start during the valid cycle
    start    = 1'b1;
    temp_raw = 13'h0199;
    tick();
    start = 1'b0;
    chk("b2b accepted busy", {31'd0, busy}, 32'd1);
    chk("b2b old data held", data, 32'h0025_0000);
    ok = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (!(busy === 1'b1 && valid === 1'b0)) ok = 1'b0;
    end
    chk("b2b busy window", {31'd0, ok}, 32'd1);
    tick();
    chk("b2b valid", {31'd0, valid}, 32'd1);
    chk("b2b data", data, 32'h0025_5625);
    tick();

    // reset abandons an in-flight conversion
    start    = 1'b1;
    temp_raw = 13'h0190;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 11; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst valid", {31'd0, valid}, 32'd0);
    chk("rst data", data, 32'h0000_0000);
    chk("rst disp_en", {31'd0, disp_en}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("rst no pulse", {31'd0, ok}, 32'd1);
    run_conv("post-rst m0.0625", 13'h1FFF, 32'hF000_0625);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/temp_bcd_formatter.md
Name: temp_bcd_formatter

Overview:
- Converts a signed 13-bit temperature sample (ADT7420 13-bit format, 0.0625 °C per LSB) into eight packed hex/BCD nibbles.
- Output is the 32-bit `data` word consumed directly by the seven-segment display driver.
- Sits between the temperature-sensor reader and the display driver.
- Iterative double-dabble engine: fixed latency, start/valid handshake, and a display-enable flag that drives the driver's `en` input.

Parameters:
- SIGN_POS, 4'h0, sign nibble emitted for temperatures >= 0
- SIGN_NEG, 4'hF, sign nibble emitted for temperatures < 0

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  single-cycle request; samples temp_raw when accepted
- temp_raw  input  13  two's-complement temperature, LSB = 1/16 °C, range -256.0000..+255.9375
- busy  output  1  high while a conversion is in progress
- valid  output  1  one-cycle pulse when data has been updated
- data  output  32  {sign, hundreds, tens, ones, tenths, hundredths, thousandths, ten-thousandths}, one nibble each, MSB first
- disp_en  output  1  low after reset; high from first valid onward; drives display enable

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, valid=0, data=32'h0, disp_en=0. Any in-flight conversion is abandoned with no valid pulse.
- FSM states: IDLE, PREP, CONV_INT, CONV_FRAC, DONE.
- IDLE:
  - start=1 → capture temp_raw and sign bit (temp_raw[12]), go to PREP, busy=1 next cycle.
  - start=0 → stay.
- PREP (1 cycle):
  - mag = sign ? (~temp_raw + 1) : temp_raw, held as 13-bit unsigned; 13'h1000 → 4096, no overflow.
  - int_bin = mag[12:4] (9 bits, 0..256).
  - frac_bin = mag[3:0] * 625 (14 bits, 0..9375).
  - Clear both BCD accumulators. Go to CONV_INT.
- CONV_INT (exactly 9 cycles):
  - Double-dabble over int_bin, MSB first, into a 12-bit accumulator (3 digits).
  - Each cycle: add 3 to every digit >= 5, then shift left one bit, taking in the next binary bit.
  - After cycle 9, go to CONV_FRAC.
- CONV_FRAC (exactly 14 cycles): same algorithm over frac_bin into a 16-bit accumulator (4 digits). Then go to DONE.
- DONE (1 cycle):
  - data <= {sign ? SIGN_NEG : SIGN_POS, int_bcd[11:0], frac_bcd[15:0]}.
  - valid=1, disp_en=1 (sticky until reset), busy=0.
  - Go to IDLE.
- Latency:
  - start sampled at edge k → busy=1 after edge k, data/valid updated at edge k+25.
  - valid is high for exactly one cycle; busy falls at the same edge valid rises.
  - Back-to-back: start may be asserted in the cycle valid is high. Next result appears 25 edges after it is sampled.
- start while busy=1 (PREP..CONV_FRAC): ignored, not queued; temp_raw changes during conversion have no effect.
- Between conversions, data holds its last value unchanged; glyphs never show partial results.
- No arithmetic wrap: every digit stays in 0..9, except the sign nibble, which is parameter-defined.

Test Plan:
- Reset, then idle 10 cycles → data=32'h00000000, disp_en=0, valid never pulses, busy=0.
- temp_raw=13'h0190 (+25.0 °C), start pulse at edge k → busy high k+1..k+24, valid single pulse at k+25, data=32'h00250000, disp_en=1.
- temp_raw=13'h0199 (+25.5625) → data=32'h00255625.
- Negative edge cases:
  - temp_raw=13'h1FFF (-0.0625) → data=32'hF0000625.
  - temp_raw=13'h1000 (-256.0) → data=32'hF2560000.
  - temp_raw=13'h0FFF (+255.9375) → data=32'h02559375.
- start with 13'h0190; re-pulse start with 13'h1FFF at k+5 → ignored, result 32'h00250000. New start during valid cycle → accepted, next result after 25 edges.
- start with 13'h0190; rst_n=0 at k+12 for one cycle → no valid pulse, data=0, disp_en=0, busy=0. Following start converts normally.
